icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Instruction-side responder to the fetch unit's ask_for/give_you handshake. Returns the 32-bit little-endian word starting at a halfword-aligned fetch address.
- Direct-mapped, read-only cache. Each line holds 4 bytes keyed by addr[31:1], so fetches that straddle a word boundary are legal.
- On a miss, fills the line by issuing 4 single-byte reads to the memory arbiter, then answers the fetch unit.
- Flush input aborts any outstanding fetch on ROB/decoder redirect.

Parameters:
- INDEX_BITS, 4, line index width; lines = 2**INDEX_BITS, index = addr[INDEX_BITS:1].
- TAG_BITS, 31-INDEX_BITS, tag = addr[31:INDEX_BITS+1].

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low freezes all state.
- ask_for  input  1  fetch request level from fetch unit.
- fetch_addr  input  32  fetch PC; bit 0 ignored; stable while ask_for=1 until give_you.
- give_you  output  1  one-cycle response-valid pulse.
- give_you_ins  output  32  instruction bytes {m[a+3],m[a+2],m[a+1],m[a]}.
- clear  input  1  flush (rob_clear | dc_clear); aborts current request.
- mem_req  output  1  byte-read request to arbiter; held until mem_done.
- mem_addr  output  32  byte address of the current read.
- mem_done  input  1  one-cycle pulse; mem_data valid.
- mem_data  input  8  returned byte.

Behaviour:
- Reset (rst_in=0, async): all valid bits 0; state IDLE; give_you=0; give_you_ins=0; mem_req=0; mem_addr=0; byte counter 0. Data/tag arrays are not reset.
- rdy_in=0: no register changes. Consumers also gate on rdy_in.
- Requests are accepted only in IDLE with give_you=0, ask_for=1, clear=0. A request present in the give_you=1 cycle is ignored.
- Hit (valid[idx] && tag match, combinational on stored arrays):
  - give_you=1 and give_you_ins=line data at the next edge.
  - Latency 1 cycle; state stays IDLE.
- Miss: latch base=fetch_addr & ~1; go to FETCH with cnt=0, mem_req=1, mem_addr=base.
- FETCH:
  - On mem_done: store mem_data into byte cnt of the fill buffer.
  - If cnt<3: cnt+=1, mem_addr=base+cnt+1, mem_req stays 1.
  - If cnt==3: write tag/data, set valid[idx], mem_req=0, give_you=1 with the assembled word, return to IDLE.
  - Miss latency = sum of arbiter latencies + 1.
- Address arithmetic is 32-bit wrapping: base 0xFFFFFFFE reads bytes FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- clear, any state:
  - give_you next cycle = 0; any pending response is dropped.
  - In IDLE: no effect beyond blocking acceptance that cycle.
  - In FETCH with mem_req=1 and no mem_done this cycle: go to DRAIN, keep mem_req=1 (the arbiter may be mid-transaction). On mem_done in DRAIN: mem_req=0, go to IDLE; the byte is discarded and the line is not written.
  - In FETCH with mem_done in the same cycle: mem_req=0, go to IDLE; the line is not written.
- clear has priority over a completing fill: the valid bit is not set.
- give_you is high for exactly one cycle per accepted, uncleared request.
- States: IDLE, FETCH, DRAIN. Registers: 2-bit counter, 32-bit base, 24-bit fill buffer.
- Reset mid-fill: returns to IDLE immediately; the arbiter must tolerate mem_req dropping.
- No writes and no coherence: instruction memory is read-only.

Decomposition:
- Shared package: state encoding (IDLE/FETCH/DRAIN), INDEX_BITS default, instruction width constant 32.
- One natural sub-module, icache_array: valid/tag/data storage, combinational lookup port and one write port, valid bits async-cleared.

Test Plan:
- Cold miss at 0x00000000, memory bytes 13 05 00 00 with one-cycle mem_done: 4 mem_req transactions at addr 0,1,2,3 -> give_you pulse with give_you_ins=0x00000513. Re-request 0x0 -> give_you one cycle after ask_for, no mem_req.
- Halfword fetch at 0x00000006 (bytes 6..9 = 01 45 85 45): mem_addr 6,7,8,9 -> give_you_ins=0x45854501. Line index 3 is valid afterwards.
- Conflict: fetch 0x00000002, then 0x00000022 (same index, INDEX_BITS=4), then 0x00000002 -> third access misses and refills.
- clear asserted while cnt=1 with mem_req pending -> DRAIN; after mem_done, mem_req=0 and no give_you. The next fetch of the same address misses.
- rdy_in=0 for 5 cycles mid-fill -> mem_addr, cnt and give_you unchanged; the fill completes correctly after rdy_in returns.
- rst_in pulsed low during FETCH -> mem_req=0 and give_you=0 asynchronously. All lines invalid: the prior hit address now misses.

Source files
------------

// File: rtl/icache_responder_pkg.sv
// Shared definitions for the instruction-cache responder: FSM encoding and
// geometry defaults used by the top level and the storage array.
package icache_responder_pkg;

  localparam int INDEX_BITS_DEF = 4;
  localparam int INS_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits (async-cleared), tags and 4-byte data,
// with a combinational lookup port and a single write port.
module icache_array
  import icache_responder_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS   = 31 - INDEX_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  input  logic [TAG_BITS-1:0]   rd_tag_i,
  output logic                  rd_hit_o,
  output logic [INS_W-1:0]      rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [INS_W-1:0]      wr_data_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [INS_W-1:0]    data_q [LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set,
  // so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_responder.sv
// Instruction-side responder: answers halfword-aligned fetches from a direct-
// mapped cache, filling missing lines with four single-byte arbiter reads.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS   = 31 - INDEX_BITS
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             ask_for,
  input  logic [31:0]      fetch_addr,
  output logic             give_you,
  output logic [INS_W-1:0] give_you_ins,
  input  logic             clear,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_done,
  input  logic [7:0]       mem_data,
  output state_e           dbg_state
);

  state_e           state_q;
  logic             give_you_q;
  logic [INS_W-1:0] ins_q;
  logic             mem_req_q;
  logic [31:0]      mem_addr_q;
  logic [1:0]       cnt_q;
  logic [31:0]      base_q, base_d;
  logic [23:0]      fill_q, fill_d;

  logic             rd_hit;
  logic [INS_W-1:0] rd_data;
  logic             accept;
  logic             wr_en;

  assign base_d = fetch_addr & 32'hFFFF_FFFE;
  assign accept = (state_q == ST_IDLE) && !give_you_q && ask_for && !clear;
  // clear wins over the last byte of a fill, so the line is never written then.
  assign wr_en  = rdy_in && (state_q == ST_FETCH) && mem_done && !clear && (cnt_q == 2'd3);

  always_comb begin
    fill_d = fill_q;
    case (cnt_q)
      2'd0:    fill_d[7:0]   = mem_data;
      2'd1:    fill_d[15:8]  = mem_data;
      2'd2:    fill_d[23:16] = mem_data;
      default: fill_d        = fill_q;
    endcase
  end

  icache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk_i    (clk_in),
    .rst_ni   (rst_in),
    .rd_idx_i (fetch_addr[INDEX_BITS:1]),
    .rd_tag_i (fetch_addr[31:INDEX_BITS+1]),
    .rd_hit_o (rd_hit),
    .rd_data_o(rd_data),
    .wr_en_i  (wr_en),
    .wr_idx_i (base_q[INDEX_BITS:1]),
    .wr_tag_i (base_q[31:INDEX_BITS+1]),
    .wr_data_i({mem_data, fill_q})
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      give_you_q <= 1'b0;
      ins_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      fill_q     <= '0;
    end else if (rdy_in) begin
      give_you_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (rd_hit) begin
              give_you_q <= 1'b1;
              ins_q      <= rd_data;
            end else begin
              base_q     <= base_d;
              mem_addr_q <= base_d;
              mem_req_q  <= 1'b1;
              cnt_q      <= '0;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (clear) begin
            // Without a completing byte the arbiter is still busy; wait it out.
            if (mem_done) begin
              mem_req_q <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (mem_done) begin
            if (cnt_q == 2'd3) begin
              give_you_q <= 1'b1;
              ins_q      <= {mem_data, fill_q};
              mem_req_q  <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              fill_q     <= fill_d;
              cnt_q      <= cnt_q + 2'd1;
              mem_addr_q <= base_q + 32'(cnt_q) + 32'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (mem_done) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign give_you     = give_you_q;
  assign give_you_ins = ins_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed and random fetches against
// a memory/cache reference model, with clear, freeze and reset scenarios.
module tb_icache_responder;
  import icache_responder_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ask_for;
  logic [31:0] fetch_addr;
  logic        give_you;
  logic [31:0] give_you_ins;
  logic        clear;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [7:0]  mem_data;
  state_e      dbg_state;

  icache_responder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .ask_for     (ask_for),
    .fetch_addr  (fetch_addr),
    .give_you    (give_you),
    .give_you_ins(give_you_ins),
    .clear       (clear),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_data    (mem_data),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // reference model: byte memory plus a 16-line direct-mapped presence map
  logic [7:0]  mem_pre [logic [31:0]];
  bit          mdl_valid [16];
  logic [30:0] mdl_line  [16];
  logic [31:0] exp_q[$];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] base);
    return {mem_byte(base + 32'd3), mem_byte(base + 32'd2),
            mem_byte(base + 32'd1), mem_byte(base)};
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 1) % 32'd16);
  endfunction

  function automatic bit mdl_hit(input logic [31:0] a);
    return mdl_valid[line_of(a)] && (mdl_line[line_of(a)] == a[31:1]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch transaction with the arbiter modelled inline (random latency).
  // freeze_at >= 0 drops rdy_in for 5 cycles while that byte is outstanding.
  task automatic do_fetch(input logic [31:0] addr, input int freeze_at);
    logic [31:0] base;
    logic [31:0] hold_a;
    bit hit, got, froze, seen_req;
    int served, lat, waited, cycles;
    base = addr & 32'hFFFF_FFFE;
    hit  = mdl_hit(addr);
    exp_q.push_back(mem_word(base));
    ask_for = 1'b1; fetch_addr = addr;
    served = 0; waited = 0; cycles = 0; got = 0; froze = 0; seen_req = 0;
    lat = $urandom_range(0, 3);
    while (!got && cycles < 200) begin
      @(negedge clk_in);
      cycles++;
      mem_done = 1'b0;
      if (give_you) begin
        got = 1; ask_for = 1'b0;
        chk("ins", give_you_ins, exp_q.pop_front());
        chk("bytes_read", served, hit ? 0 : 4);
        chk("mem_req_at_give", mem_req, 1'b0);
        if (hit) chk("hit_latency", cycles, 1);
      end else if (mem_req) begin
        if (!seen_req) begin
          seen_req = 1;
          chk("miss_req_latency", cycles, 1);
        end
        chk("mem_addr", mem_addr, base + served);
        if (freeze_at == served && !froze) begin
          froze = 1; hold_a = mem_addr;
          rdy_in = 1'b0; mem_done = 1'b1; mem_data = mem_byte(base + served);
          repeat (5) begin
            @(negedge clk_in);
            chk("frz_addr", mem_addr, hold_a);
            chk("frz_req", mem_req, 1'b1);
            chk("frz_give", give_you, 1'b0);
          end
          rdy_in = 1'b1;
          served++; waited = 0; lat = $urandom_range(0, 3);
        end else if (waited >= lat) begin
          mem_done = 1'b1; mem_data = mem_byte(base + served);
          served++; waited = 0; lat = $urandom_range(0, 3);
        end else begin
          waited++;
        end
      end
    end
    if (!got) begin
      chk("give_you_timeout", 32'd0, 32'd1);
      exp_q.delete();
      ask_for = 1'b0;
    end else begin
      mdl_valid[line_of(addr)] = 1'b1;
      mdl_line[line_of(addr)]  = addr[31:1];
    end
    @(negedge clk_in);
    mem_done = 1'b0;
    chk("give_you_pulse", give_you, 1'b0);
  endtask

  // Start a miss and serve bytes until byte k is outstanding (mem_req high).
  task automatic start_fill(input logic [31:0] addr, input int k, output int ok);
    logic [31:0] base;
    int served, cycles;
    base = addr & 32'hFFFF_FFFE;
    ask_for = 1'b1; fetch_addr = addr;
    served = 0; cycles = 0; ok = 0;
    while (!ok && cycles < 100) begin
      @(negedge clk_in);
      cycles++;
      mem_done = 1'b0;
      if (mem_req && served == k) ok = 1;
      else if (mem_req) begin
        mem_done = 1'b1; mem_data = mem_byte(base + served); served++;
      end
    end
    if (!ok) chk("fill_start_timeout", 32'd0, 32'd1);
    else chk("fill_addr_k", mem_addr, base + k);
  endtask

  task automatic do_clear(input logic [31:0] addr, input int k, input bit same);
    int ok;
    start_fill(addr, k, ok);
    clear = 1'b1; ask_for = 1'b0;
    mem_done = same; mem_data = mem_byte((addr & 32'hFFFF_FFFE) + k);
    @(negedge clk_in);
    clear = 1'b0; mem_done = 1'b0;
    chk("clr_give", give_you, 1'b0);
    if (same) begin
      chk("clr_done_req", mem_req, 1'b0);
      chk("clr_done_state", dbg_state, ST_IDLE);
    end else begin
      chk("drain_state", dbg_state, ST_DRAIN);
      chk("drain_req", mem_req, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk_in);
        chk("drain_hold", mem_req, 1'b1);
      end
      mem_done = 1'b1; mem_data = 8'hEE;
      @(negedge clk_in);
      mem_done = 1'b0;
      chk("drain_end_req", mem_req, 1'b0);
      chk("drain_end_state", dbg_state, ST_IDLE);
    end
    repeat (2) begin
      @(negedge clk_in);
      chk("clr_no_give", give_you, 1'b0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] region;
    case ($urandom_range(0, 3))
      0:       region = 32'h0000_0000;
      1:       region = 32'h0000_0020;
      2:       region = 32'h0000_1000;
      default: region = 32'hFFFF_FFE0;
    endcase
    return region + $urandom_range(0, 31);
  endfunction

  initial begin
    int ok;
    rst_in = 1'b0; rdy_in = 1'b1; ask_for = 1'b0; clear = 1'b0;
    fetch_addr = '0; mem_done = 1'b0; mem_data = '0;
    foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
    mem_pre[32'h0] = 8'h13; mem_pre[32'h1] = 8'h05; mem_pre[32'h2] = 8'h00; mem_pre[32'h3] = 8'h00;
    mem_pre[32'h6] = 8'h01; mem_pre[32'h7] = 8'h45; mem_pre[32'h8] = 8'h85; mem_pre[32'h9] = 8'h45;
    repeat (2) @(negedge clk_in);
    chk("rst_give", give_you, 1'b0);
    chk("rst_ins", give_you_ins, 32'h0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_in = 1'b1;
    @(negedge clk_in);

    do_fetch(32'h0, -1);
    chk("word_0", mem_word(32'h0), 32'h0000_0513);
    do_fetch(32'h0, -1);
    do_fetch(32'h6, -1);
    do_fetch(32'h6, -1);
    do_fetch(32'h2, -1);
    do_fetch(32'h22, -1);
    do_fetch(32'h2, -1);

    do_clear(32'h40, 1, 1'b0);
    do_fetch(32'h40, -1);
    do_clear(32'h60, 3, 1'b1);
    do_fetch(32'h60, -1);
    do_clear(32'h80, 0, 1'b0);

    // clear in the same cycle as a hit request blocks acceptance
    ask_for = 1'b1; fetch_addr = 32'h0; clear = 1'b1;
    @(negedge clk_in);
    ask_for = 1'b0; clear = 1'b0;
    chk("clr_hit_give", give_you, 1'b0);
    chk("clr_hit_req", mem_req, 1'b0);
    @(negedge clk_in);
    chk("clr_hit_give2", give_you, 1'b0);

    do_fetch(32'h100, 1);
    do_fetch(32'hFFFF_FFFE, -1);
    do_fetch(32'hFFFF_FFFE, -1);

    for (int n = 0; n < 60; n++) do_fetch(rand_addr(), ($urandom_range(0, 7) == 0) ? 2 : -1);

    // asynchronous reset in the middle of a fill
    do_fetch(32'h0, -1);
    start_fill(32'h200, 2, ok);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_give", give_you, 1'b0);
    chk("arst_state", dbg_state, ST_IDLE);
    ask_for = 1'b0; mem_done = 1'b0;
    foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    do_fetch(32'h0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
